// File: rtl/clk_pkg.sv
// clk_pkg: shared clocking constants for the clock-enable generator and its users.
package clk_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int SYS_CLK_HZ = 100_000_000;
  localparam int DIV_NN = 2;
  localparam int DIV_PIX = 4;
endpackage

// File: rtl/clk_en_ch.sv
// clk_en_ch: one divider channel with tick, divided clock and boundary-aligned divisor update.
module clk_en_ch #(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] DIV_INIT = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_tick,
  output logic             o_clk,
  output logic [CNT_W-1:0] o_div
);
  logic [CNT_W-1:0] cnt, div, pend_div, nxt_pend_div, nxt_div, nxt_cnt;
  logic pend, nxt_pend, wrap, apply;
  // A write landing on the same cycle as a boundary is taken by that boundary.
  always_comb begin
    nxt_pend_div = i_wr ? i_wr_div : pend_div;
    nxt_pend = i_wr | pend;
    wrap = i_en && cnt == div - CNT_W'(1);
    apply = nxt_pend && (wrap || i_sync || !i_en);
    nxt_div = apply ? nxt_pend_div : div;
    nxt_cnt = (!i_en || wrap || i_sync) ? '0 : cnt + CNT_W'(1);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt <= '0;
      div <= DIV_INIT;
      pend_div <= '0;
      pend <= 1'b0;
      o_tick <= 1'b0;
      o_clk <= 1'b0;
    end else begin
      cnt <= nxt_cnt;
      div <= nxt_div;
      pend_div <= nxt_pend_div;
      pend <= nxt_pend && !apply;
      o_tick <= wrap;
      o_clk <= i_en && nxt_cnt < (nxt_div >> 1);
    end
  end
  assign o_div = div;
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel clock-enable / divided-clock generator with runtime divisors.
module clk_en_gen
  import clk_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W_DEF'(DIV_PIX), CNT_W_DEF'(DIV_NN)},
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_CH-1:0]       i_en,
  input  logic                    i_sync,
  input  logic                    i_wr_valid,
  input  logic [CH_W-1:0]         i_wr_ch,
  input  logic [CNT_W-1:0]        i_wr_div,
  output logic                    o_wr_err,
  output logic [NUM_CH-1:0]       o_tick,
  output logic [NUM_CH-1:0]       o_clk,
  output logic [NUM_CH*CNT_W-1:0] o_div
);
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);
  logic wr_ok;
  assign wr_ok = i_wr_div != '0 && {1'b0, i_wr_ch} < NCH;
  always_ff @(posedge i_clk) o_wr_err <= !i_reset && i_wr_valid && !wr_ok;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_en_ch #(
      .CNT_W(CNT_W),
      .DIV_INIT(DIV_INIT[k*CNT_W +: CNT_W])
    ) u_ch (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_en(i_en[k]),
      .i_sync(i_sync),
      .i_wr(i_wr_valid && wr_ok && i_wr_ch == CH_W'(k)),
      .i_wr_div(i_wr_div),
      .o_tick(o_tick[k]),
      .o_clk(o_clk[k]),
      .o_div(o_div[k*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: table, directed and random checks of clk_en_gen against a period-start-time model.
module tb_clk_en_gen;
  localparam int N = 3;
  localparam logic [47:0] D_A = {16'd3, 16'd4, 16'd2};
  localparam logic [47:0] D_B = {16'd3, 16'd3, 16'd2};
  localparam logic [47:0] D_C = {16'd3, 16'd3, 16'd7};
  logic clk = 1'b0, rst = 1'b1, sync = 1'b0, wv = 1'b0;
  logic [N-1:0] en = '1;
  logic [1:0] wch = '0;
  logic [15:0] wdiv = '0;
  logic wr_err;
  logic [N-1:0] tick, oclk;
  logic [47:0] odiv;
  int n_cmp = 0, n_bad = 0, t = 0;
  bit armed = 0;
  int start[N], d[N], pv[N];
  bit pp[N];
  logic [N-1:0] e_tick, e_clk;
  logic e_err;
  typedef struct {
    logic wv;
    logic [1:0] wch;
    logic [15:0] wdiv;
    logic [N-1:0] tk;
    logic [N-1:0] ck;
    logic er;
    logic [47:0] dv;
  } vec_t;
  vec_t tv[10];

  clk_en_gen #(.NUM_CH(N), .CNT_W(16), .DIV_INIT(D_A)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_sync(sync), .i_wr_valid(wv),
    .i_wr_ch(wch), .i_wr_div(wdiv), .o_wr_err(wr_err), .o_tick(tick),
    .o_clk(oclk), .o_div(odiv)
  );

  always #5 clk = ~clk;

  function automatic vec_t row(logic a, logic [1:0] c, logic [15:0] v, logic [N-1:0] tk,
                               logic [N-1:0] ck, logic er, logic [47:0] dv);
    row = '{a, c, v, tk, ck, er, dv};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  function automatic logic [47:0] model_div();
    logic [47:0] r;
    for (int k = 0; k < N; k++) r[k*16 +: 16] = 16'(d[k]);
    return r;
  endfunction

  // Each channel is described by the cycle its current period began and its divisor.
  task automatic model_update();
    t++;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        start[k] = t;
        d[k] = int'(D_A[k*16 +: 16]);
        pp[k] = 0;
      end
      e_tick = '0;
      e_clk = '0;
      e_err = 1'b0;
    end else begin
      e_err = wv && (wdiv == 0 || wch >= N);
      for (int k = 0; k < N; k++) begin
        if (wv && !e_err && wch == k) begin
          pv[k] = wdiv;
          pp[k] = 1;
        end
        if (!en[k]) begin
          start[k] = t;
          if (pp[k]) begin d[k] = pv[k]; pp[k] = 0; end
          e_tick[k] = 1'b0;
          e_clk[k] = 1'b0;
        end else begin
          e_tick[k] = (t - start[k]) == d[k];
          if (e_tick[k] || sync) begin
            start[k] = t;
            if (pp[k]) begin d[k] = pv[k]; pp[k] = 0; end
          end
          e_clk[k] = (t - start[k]) < d[k] / 2;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (armed) begin
      chk("model_tick", tick, e_tick);
      chk("model_clk", oclk, e_clk);
      chk("model_err", wr_err, e_err);
      chk("model_div", odiv, model_div());
    end
  endtask

  initial begin
    tv[0] = row(0, 0, 0, 3'b000, 3'b000, 0, D_A);
    tv[1] = row(1, 1, 3, 3'b000, 3'b010, 0, D_A);
    tv[2] = row(0, 0, 0, 3'b001, 3'b001, 0, D_A);
    tv[3] = row(0, 0, 0, 3'b100, 3'b100, 0, D_A);
    tv[4] = row(1, 0, 5, 3'b011, 3'b011, 0, D_B);
    tv[5] = row(1, 0, 7, 3'b000, 3'b000, 0, D_B);
    tv[6] = row(1, 0, 0, 3'b101, 3'b101, 0, D_C);
    tv[7] = row(1, 3, 9, 3'b010, 3'b011, 1, D_C);
    tv[8] = row(0, 0, 0, 3'b000, 3'b001, 1, D_C);
    tv[9] = row(0, 0, 0, 3'b100, 3'b100, 0, D_C);
    @(negedge clk);
    step();
    armed = 1;
    rst = 1'b0;
    chk("reset_div", odiv, D_A);
    chk("reset_outs", {tick, oclk, wr_err}, 7'd0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tbl%0d_tick", i), tick, tv[i].tk);
      chk($sformatf("tbl%0d_clk", i), oclk, tv[i].ck);
      chk($sformatf("tbl%0d_err", i), wr_err, tv[i].er);
      chk($sformatf("tbl%0d_div", i), odiv, tv[i].dv);
      wv = tv[i].wv;
      wch = tv[i].wch;
      wdiv = tv[i].wdiv;
      step();
    end
    wv = 1'b0;
    wv = 1'b1; wch = 2'd0; wdiv = 16'd4;
    step();
    wv = 1'b0;
    repeat (12) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_div", odiv, {16'd3, 16'd3, 16'd4});
    for (int j = 1; j <= 12; j++) begin
      step();
      chk($sformatf("sync_tick0_%0d", j), tick[0], j % 4 == 0);
      chk($sformatf("sync_tick1_%0d", j), tick[1], j % 3 == 0);
    end
    wv = 1'b1; wch = 2'd1; wdiv = 16'd5;
    step();
    wv = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_div", odiv, D_A);
    chk("rst2_outs", {tick, oclk, wr_err}, 7'd0);
    en = 3'b110;
    repeat (5) begin
      step();
      chk("dis_tick0", tick[0], 1'b0);
      chk("dis_clk0", oclk[0], 1'b0);
    end
    en = 3'b111;
    step();
    chk("reen_tick0_1", tick[0], 1'b0);
    step();
    chk("reen_tick0_2", tick[0], 1'b1);
    chk("rst2_div_kept", odiv, D_A);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      for (int k = 0; k < N; k++) en[k] = $urandom_range(0, 9) != 0;
      sync = $urandom_range(0, 29) == 0;
      wv = $urandom_range(0, 5) == 0;
      wch = 2'($urandom_range(0, 3));
      wdiv = 16'($urandom_range(0, 7));
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
